rodada_noite: RTL and testbench
===============================

Name: rodada_noite

Overview:
- Night-phase resolution engine for the werewolf game datapath, generalised to NUM_PLAYERS players.
- Collects per-player night actions: multiple werewolves vote on a victim, and the protector names one player to save.
- Tallies wolf votes and eliminates the winning target unless protected.
- Maintains the alive mask and flags end-of-game; sits between the game-control FSM and the display/debug logic.

Parameters:
- NUM_PLAYERS, 5, number of players (2..16).
- PLAYER_W, 3, index width; must satisfy 2^PLAYER_W >= NUM_PLAYERS.
- VOTE_W, 3, vote-counter width; must satisfy 2^VOTE_W > NUM_PLAYERS.

Ports:
- clock  in  1  system clock.
- rst_global_n  in  1  synchronous active-low reset.
- novo_jogo  in  1  pulse; clears the alive mask and protection history.
- lobos_mask  in  NUM_PLAYERS  bit i = player i is a wolf; held static during a game.
- inicia_noite  in  1  pulse; starts collecting actions.
- acao_valid  in  1  one action per cycle while in COLETA.
- acao_ator  in  PLAYER_W  acting player.
- acao_classe  in  2  00 villager, 01 wolf, 10 protector, 11 seer.
- acao_alvo  in  PLAYER_W  chosen player.
- encerra_noite  in  1  pulse; ends collection and starts resolution.
- ocupado  out  1  high in any state except IDLE.
- noite_pronta  out  1  one-cycle pulse when the night has been resolved.
- vitima_valid  out  1  held high when the last night killed someone.
- vitima  out  PLAYER_W  index of the last victim.
- vivos_mask  out  NUM_PLAYERS  bit i = player i alive.
- num_vivos  out  PLAYER_W+1  count of alive players.
- fim_jogo  out  1  game over.
- vitoria_lobos  out  1  valid when fim_jogo is high; 1 = wolves won.
- db_estado  out  3  FSM state code.

Behaviour:

Reset (rst_global_n = 0 at a clock edge):
- State goes to IDLE; vivos_mask = all ones; num_vivos = NUM_PLAYERS; vote counters = 0.
- vitima = 0; vitima_valid = 0; noite_pronta = 0; fim_jogo = 0; vitoria_lobos = 0.
- Protection history is empty.
- Reset overrides everything, including mid-night.

novo_jogo:
- Accepted only in IDLE, with the same effect as reset.
- Ignored in any other state.

FSM states: IDLE=0, COLETA=1, APURA=2, ELIMINA=3, FIM=4.

IDLE:
- inicia_noite moves to COLETA, provided fim_jogo = 0.
- On entry to COLETA: clear vote counters, clear protegido_valid.

COLETA: each cycle with acao_valid is processed as follows.
- Ignore the action if the actor is dead, the target is dead, or acao_alvo >= NUM_PLAYERS.
- Class 01 is honoured only if lobos_mask[acao_ator] = 1. Its effect is votos[acao_alvo] += 1, saturating at the maximum count.
- Class 10: protegido <= acao_alvo and protegido_valid <= 1, unless acao_alvo equals the previous night's protected player. Such a repeat is rejected.
- If several protector actions arrive, the last accepted one wins.
- Class 00 is ignored. Class 11 is ignored unless VIDENTE_EN is defined.
- encerra_noite moves to APURA. An acao_valid in the same cycle as encerra_noite is still processed.

APURA:
- Scans index i = 0..NUM_PLAYERS-1, one per cycle (NUM_PLAYERS cycles), tracking the maximum vote count.
- A later index replaces the current best only if its count is strictly greater, so ties go to the lowest index.
- Then moves to ELIMINA.

ELIMINA (1 cycle):
- If max votes = 0: no victim.
- If the winning target equals protegido and protegido_valid = 1: no victim.
- Otherwise clear vivos_mask[alvo], decrement num_vivos, set vitima = alvo and vitima_valid = 1.
- With no victim, vitima_valid = 0 and vitima holds its old value.
- Update the protection history: previous-night protected = protegido if protegido_valid, else empty.
- Move to FIM.

FIM (1 cycle):
- Pulse noite_pronta.
- Compute lobos_vivos = popcount(vivos_mask & lobos_mask) and aldeoes_vivos = num_vivos - lobos_vivos.
- If lobos_vivos = 0: fim_jogo = 1, vitoria_lobos = 0.
- Else if lobos_vivos >= aldeoes_vivos: fim_jogo = 1, vitoria_lobos = 1.
- Return to IDLE.

Latency:
- From encerra_noite to the noite_pronta pulse is NUM_PLAYERS + 3 cycles.

Other pulses:
- inicia_noite outside IDLE and encerra_noite outside COLETA are ignored.
- fim_jogo stays set until reset or novo_jogo.

Optional Feature:
Macro RODADA_NOITE_VIDENTE_EN.
- When defined: adds outputs revela_valid (1 bit) and revela_lobo (1 bit).
- A class-11 action from a living actor with a valid living target pulses revela_valid on the next cycle, with revela_lobo = lobos_mask[acao_alvo].
- Only the first seer action per night is honoured.
- When undefined: the ports are absent and class 11 is ignored.

Decomposition:
- A shared package lobinho_pkg holds:
  - classe_t enum: ALDEAO=2'b00, LOBO=2'b01, PROTETOR=2'b10, VIDENTE=2'b11.
  - estado_noite_t enum with the FSM codes above.
  - Default constants NUM_PLAYERS_DEF=5 and PLAYER_W_DEF=3.
- One sub-module is natural: contador_votos. It holds the NUM_PLAYERS saturating counters with clear, a single-index increment and a read port indexed by the scan pointer.

Test Plan:
- Reset then idle → vivos_mask=5'b11111, num_vivos=5, fim_jogo=0, db_estado=0.
- lobos_mask=5'b00010; wolf 1 votes target 3; protector 2 protects 4; encerra_noite → noite_pronta after 8 cycles, vitima=3, vivos_mask=5'b10111, num_vivos=4.
- Same night, but the protector protects 3 → vitima_valid=0, vivos_mask unchanged.
- Protector protects 3 on night 1; on night 2 protects 3 again and the wolf attacks 3 → protection rejected, player 3 dies.
- lobos_mask=5'b00011; wolves vote 2 and 4 (tie) → vitima=2 (lowest index).
- Repeated eliminations until wolves equal villagers (2 vs 2) → fim_jogo=1, vitoria_lobos=1; a further inicia_noite is ignored. Under RODADA_NOITE_VIDENTE_EN, seer 4 targets 1 → revela_valid pulse, revela_lobo=1.

Source files
------------

// File: rtl/lobinho_pkg.sv
// -----------------------------------------------------------------------------
// lobinho_pkg
// Shared types and constants for the werewolf night-resolution datapath.
//   classe_t       : action class carried by acao_classe.
//   estado_noite_t : FSM state codes, also exported on db_estado.
//   popcount16     : population count used to count the wolves still alive.
// Optional feature macro used by this slice: RODADA_NOITE_VIDENTE_EN.
// -----------------------------------------------------------------------------
package lobinho_pkg;

    typedef enum logic [1:0] {
        ALDEAO   = 2'b00,
        LOBO     = 2'b01,
        PROTETOR = 2'b10,
        VIDENTE  = 2'b11
    } classe_t;

    typedef enum logic [2:0] {
        EST_IDLE    = 3'd0,
        EST_COLETA  = 3'd1,
        EST_APURA   = 3'd2,
        EST_ELIMINA = 3'd3,
        EST_FIM     = 3'd4
    } estado_noite_t;

    localparam int NUM_PLAYERS_DEF = 5;
    localparam int PLAYER_W_DEF    = 3;
    localparam int VOTE_W_DEF      = 3;

    // Up to 16 players, so a 16-bit popcount covers every legal configuration.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rodada_noite_if.sv
// -----------------------------------------------------------------------------
// rodada_noite_if
// Bundles the control/action inputs and the status outputs of rodada_noite.
//   master : game-control side (drives pulses and actions, reads status).
//   slave  : the night engine itself.
// Inputs : novo_jogo, lobos_mask, inicia_noite, acao_valid, acao_ator,
//          acao_classe, acao_alvo, encerra_noite.
// Outputs: ocupado, noite_pronta, vitima_valid, vitima, vivos_mask, num_vivos,
//          fim_jogo, vitoria_lobos, db_estado
//          (+ revela_valid, revela_lobo when RODADA_NOITE_VIDENTE_EN is defined).
// -----------------------------------------------------------------------------
interface rodada_noite_if
    import lobinho_pkg::*;
#(
    parameter int NUM_PLAYERS = NUM_PLAYERS_DEF,
    parameter int PLAYER_W    = PLAYER_W_DEF
) ();

    logic                   novo_jogo;
    logic [NUM_PLAYERS-1:0] lobos_mask;
    logic                   inicia_noite;
    logic                   acao_valid;
    logic [PLAYER_W-1:0]    acao_ator;
    classe_t                acao_classe;
    logic [PLAYER_W-1:0]    acao_alvo;
    logic                   encerra_noite;

    logic                   ocupado;
    logic                   noite_pronta;
    logic                   vitima_valid;
    logic [PLAYER_W-1:0]    vitima;
    logic [NUM_PLAYERS-1:0] vivos_mask;
    logic [PLAYER_W:0]      num_vivos;
    logic                   fim_jogo;
    logic                   vitoria_lobos;
    logic [2:0]             db_estado;
`ifdef RODADA_NOITE_VIDENTE_EN
    logic                   revela_valid;
    logic                   revela_lobo;
`endif

    modport master (
        output novo_jogo, lobos_mask, inicia_noite, acao_valid, acao_ator,
               acao_classe, acao_alvo, encerra_noite,
`ifdef RODADA_NOITE_VIDENTE_EN
        input  revela_valid, revela_lobo,
`endif
        input  ocupado, noite_pronta, vitima_valid, vitima, vivos_mask,
               num_vivos, fim_jogo, vitoria_lobos, db_estado
    );

    modport slave (
        input  novo_jogo, lobos_mask, inicia_noite, acao_valid, acao_ator,
               acao_classe, acao_alvo, encerra_noite,
`ifdef RODADA_NOITE_VIDENTE_EN
        output revela_valid, revela_lobo,
`endif
        output ocupado, noite_pronta, vitima_valid, vitima, vivos_mask,
               num_vivos, fim_jogo, vitoria_lobos, db_estado
    );

endinterface

// File: rtl/rodada_noite_contador_votos.sv
// -----------------------------------------------------------------------------
// contador_votos
// NUM_PLAYERS saturating wolf-vote counters.
//   clock, rst_global_n : clock and synchronous active-low reset.
//   clr                 : synchronous clear of every counter.
//   inc_en, inc_idx     : add one vote to counter inc_idx (saturates).
//   rd_idx, rd_cnt      : combinational read port used by the tally scan.
// -----------------------------------------------------------------------------
module contador_votos
    import lobinho_pkg::*;
#(
    parameter int NUM_PLAYERS = NUM_PLAYERS_DEF,
    parameter int PLAYER_W    = PLAYER_W_DEF,
    parameter int VOTE_W      = VOTE_W_DEF
) (
    input  logic                clock,
    input  logic                rst_global_n,
    input  logic                clr,
    input  logic                inc_en,
    input  logic [PLAYER_W-1:0] inc_idx,
    input  logic [PLAYER_W-1:0] rd_idx,
    output logic [VOTE_W-1:0]   rd_cnt
);

    localparam logic [VOTE_W-1:0] CNT_MAX = '1;

    logic [VOTE_W-1:0] votos [NUM_PLAYERS];

    // NOTE: the counter array is small and must read zero after reset, so it is
    // reset like ordinary flops; a large RAM would instead be cleared by a sweep.
    // NOTE: sequential state uses <= so every counter sees the pre-edge values.
    always_ff @(posedge clock) begin
        if (!rst_global_n || clr) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                votos[i] <= '0;
            end
        end else if (inc_en) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (inc_idx == PLAYER_W'(i) && votos[i] != CNT_MAX) begin
                    votos[i] <= votos[i] + 1'b1;
                end
            end
        end
    end

    // Index compare instead of a direct array index keeps out-of-range
    // pointers harmless.
    always_comb begin
        // NOTE: default first so no path leaves rd_cnt unassigned (no latch).
        rd_cnt = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (rd_idx == PLAYER_W'(i)) begin
                rd_cnt = votos[i];
            end
        end
    end

endmodule

// File: rtl/rodada_noite.sv
// -----------------------------------------------------------------------------
// rodada_noite
// Night-phase resolution engine: collects wolf votes and the protector's
// choice, tallies the votes, eliminates the winner unless protected, keeps the
// alive mask and detects the end of the game.
//   clock, rst_global_n : clock and synchronous active-low reset.
//   bus (slave)         : actions/pulses in, status out (see rodada_noite_if).
// Optional feature: define RODADA_NOITE_VIDENTE_EN to add the seer reveal
// outputs revela_valid / revela_lobo.
// -----------------------------------------------------------------------------
module rodada_noite
    import lobinho_pkg::*;
#(
    parameter int NUM_PLAYERS = NUM_PLAYERS_DEF,
    parameter int PLAYER_W    = PLAYER_W_DEF,
    parameter int VOTE_W      = VOTE_W_DEF
) (
    input  logic          clock,
    input  logic          rst_global_n,
    rodada_noite_if.slave bus
);

    localparam logic [2:0] S_IDLE    = EST_IDLE;
    localparam logic [2:0] S_COLETA  = EST_COLETA;
    localparam logic [2:0] S_APURA   = EST_APURA;
    localparam logic [2:0] S_ELIMINA = EST_ELIMINA;
    localparam logic [2:0] S_FIM     = EST_FIM;

    localparam int EXT_W = 1 << PLAYER_W;
    localparam int CNT_W = PLAYER_W + 1;

    logic [2:0]             estado;
    logic [NUM_PLAYERS-1:0] vivos;
    logic [CNT_W-1:0]       num_vivos;
    logic [PLAYER_W-1:0]    vitima;
    logic                   vitima_valid;
    logic                   noite_pronta;
    logic                   fim_jogo;
    logic                   vitoria_lobos;
    logic [PLAYER_W-1:0]    protegido;
    logic                   protegido_valid;
    logic [PLAYER_W-1:0]    prev_prot;
    logic                   prev_prot_valid;
    logic [PLAYER_W-1:0]    scan_idx;
    logic [PLAYER_W-1:0]    best_idx;
    logic [VOTE_W-1:0]      best_cnt;
    logic [VOTE_W-1:0]      rd_cnt;

    // Masks padded to the full index range: any index >= NUM_PLAYERS reads as
    // "dead / not a wolf", which folds the range check into the alive check.
    logic [EXT_W-1:0]       vivos_ext;
    logic [EXT_W-1:0]       lobos_ext;

    logic                   novo_ok;
    logic                   inicia_ok;
    logic                   acao_ok;
    logic                   voto_ok;
    logic                   prot_ok;
    logic                   last_scan;
    logic                   tem_vitima;
    logic                   clr_votos;
    logic [CNT_W-1:0]       lobos_vivos;
    logic [CNT_W-1:0]       aldeoes_vivos;

    assign vivos_ext = EXT_W'(vivos);
    assign lobos_ext = EXT_W'(bus.lobos_mask);

    // novo_jogo wins over inicia_noite when both arrive in IDLE.
    assign novo_ok   = (estado == S_IDLE) && bus.novo_jogo;
    assign inicia_ok = (estado == S_IDLE) && bus.inicia_noite && !fim_jogo && !bus.novo_jogo;

    assign acao_ok = (estado == S_COLETA) && bus.acao_valid
                     && vivos_ext[bus.acao_ator] && vivos_ext[bus.acao_alvo];
    assign voto_ok = acao_ok && (bus.acao_classe == LOBO) && lobos_ext[bus.acao_ator];
    // Protecting the same player two nights in a row is rejected.
    assign prot_ok = acao_ok && (bus.acao_classe == PROTETOR)
                     && !(prev_prot_valid && (bus.acao_alvo == prev_prot));

    assign last_scan  = (scan_idx == PLAYER_W'(NUM_PLAYERS - 1));
    assign tem_vitima = (best_cnt != '0) && !(protegido_valid && (best_idx == protegido));
    assign clr_votos  = novo_ok || inicia_ok;

    assign lobos_vivos   = CNT_W'(popcount16(16'(vivos & bus.lobos_mask)));
    assign aldeoes_vivos = num_vivos - lobos_vivos;

    contador_votos #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .PLAYER_W    (PLAYER_W),
        .VOTE_W      (VOTE_W)
    ) u_votos (
        .clock        (clock),
        .rst_global_n (rst_global_n),
        .clr          (clr_votos),
        .inc_en       (voto_ok),
        .inc_idx      (bus.acao_alvo),
        .rd_idx       (scan_idx),
        .rd_cnt       (rd_cnt)
    );

    always_ff @(posedge clock) begin
        if (!rst_global_n || novo_ok) begin
            estado          <= S_IDLE;
            vivos           <= '1;
            num_vivos       <= CNT_W'(NUM_PLAYERS);
            vitima          <= '0;
            vitima_valid    <= 1'b0;
            noite_pronta    <= 1'b0;
            fim_jogo        <= 1'b0;
            vitoria_lobos   <= 1'b0;
            protegido       <= '0;
            protegido_valid <= 1'b0;
            prev_prot       <= '0;
            prev_prot_valid <= 1'b0;
            scan_idx        <= '0;
            best_idx        <= '0;
            best_cnt        <= '0;
        end else begin
            noite_pronta <= 1'b0;
            case (estado)
                S_IDLE: begin
                    if (inicia_ok) begin
                        estado          <= S_COLETA;
                        protegido_valid <= 1'b0;
                    end
                end
                S_COLETA: begin
                    if (prot_ok) begin
                        protegido       <= bus.acao_alvo;
                        protegido_valid <= 1'b1;
                    end
                    if (bus.encerra_noite) begin
                        estado   <= S_APURA;
                        scan_idx <= '0;
                        best_idx <= '0;
                        best_cnt <= '0;
                    end
                end
                S_APURA: begin
                    // Strictly greater: ties stay with the lowest index.
                    if (rd_cnt > best_cnt) begin
                        best_cnt <= rd_cnt;
                        best_idx <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                    if (last_scan) begin
                        estado <= S_ELIMINA;
                    end
                end
                S_ELIMINA: begin
                    if (tem_vitima) begin
                        vivos        <= vivos & ~(NUM_PLAYERS'(1) << best_idx);
                        num_vivos    <= num_vivos - 1'b1;
                        vitima       <= best_idx;
                        vitima_valid <= 1'b1;
                    end else begin
                        vitima_valid <= 1'b0;
                    end
                    prev_prot       <= protegido;
                    prev_prot_valid <= protegido_valid;
                    estado          <= S_FIM;
                end
                S_FIM: begin
                    noite_pronta <= 1'b1;
                    if (lobos_vivos == '0) begin
                        fim_jogo      <= 1'b1;
                        vitoria_lobos <= 1'b0;
                    end else if (lobos_vivos >= aldeoes_vivos) begin
                        fim_jogo      <= 1'b1;
                        vitoria_lobos <= 1'b1;
                    end
                    estado <= S_IDLE;
                end
                default: estado <= S_IDLE;
            endcase
        end
    end

`ifdef RODADA_NOITE_VIDENTE_EN
    logic revela_valid;
    logic revela_lobo;
    logic vidente_usado;

    // Only the first honoured seer action of a night produces a reveal.
    always_ff @(posedge clock) begin
        if (!rst_global_n || novo_ok) begin
            revela_valid  <= 1'b0;
            revela_lobo   <= 1'b0;
            vidente_usado <= 1'b0;
        end else begin
            revela_valid <= 1'b0;
            if (inicia_ok) begin
                vidente_usado <= 1'b0;
            end else if (acao_ok && (bus.acao_classe == VIDENTE) && !vidente_usado) begin
                revela_valid  <= 1'b1;
                revela_lobo   <= lobos_ext[bus.acao_alvo];
                vidente_usado <= 1'b1;
            end
        end
    end

    assign bus.revela_valid = revela_valid;
    assign bus.revela_lobo  = revela_lobo;
`endif

    assign bus.ocupado       = (estado != S_IDLE);
    assign bus.noite_pronta  = noite_pronta;
    assign bus.vitima_valid  = vitima_valid;
    assign bus.vitima        = vitima;
    assign bus.vivos_mask    = vivos;
    assign bus.num_vivos     = num_vivos;
    assign bus.fim_jogo      = fim_jogo;
    assign bus.vitoria_lobos = vitoria_lobos;
    assign bus.db_estado     = estado;

endmodule

// File: tb/tb_rodada_noite.sv
// -----------------------------------------------------------------------------
// tb_rodada_noite
// Self-checking bench for rodada_noite (5 players). A night-level model keeps
// the alive set, last victim, protection history and game outcome; a compare
// process checks every idle cycle against it, and directed scenarios pin a few
// literal results. Define RODADA_NOITE_VIDENTE_EN to also check seer reveals.
// -----------------------------------------------------------------------------
module tb_rodada_noite;
    import lobinho_pkg::*;

    localparam int NP   = 5;
    localparam int PW   = 3;
    localparam int VW   = 3;
    localparam int VMAX = (1 << VW) - 1;

    logic clock = 1'b0;
    logic rst_global_n = 1'b0;
    always #5 clock = ~clock;

    rodada_noite_if #(.NUM_PLAYERS(NP), .PLAYER_W(PW)) bus ();

    rodada_noite #(.NUM_PLAYERS(NP), .PLAYER_W(PW), .VOTE_W(VW)) dut (
        .clock        (clock),
        .rst_global_n (rst_global_n),
        .bus          (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Night-level model state.
    bit          m_alive [NP];
    bit [NP-1:0] m_lobos;
    int          m_nvivos;
    int          m_vitima;
    bit          m_vvalid;
    bit          m_fim;
    bit          m_vl;
    int          m_prev;     // -1 = nobody protected last night

    int q_ator[$];
    int q_cls[$];
    int q_alvo[$];
    bit q_rv[$];
    bit q_rl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] m_mask();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = m_alive[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_alive[i] = 1'b1;
        m_nvivos = NP;
        m_vitima = 0;
        m_vvalid = 1'b0;
        m_fim    = 1'b0;
        m_vl     = 1'b0;
        m_prev   = -1;
    endtask

    // Resolves the queued night from the game rules.
    task automatic model_night();
        int votos [NP];
        int prot = -1;
        bit seer_used = 1'b0;
        int best = 0;
        int bmax = 0;
        int lv = 0;
        q_rv.delete();
        q_rl.delete();
        for (int i = 0; i < NP; i++) votos[i] = 0;
        for (int i = 0; i < q_ator.size(); i++) begin
            bit ok = 1'b0;
            bit rv = 1'b0;
            bit rl = 1'b0;
            if (q_ator[i] < NP && q_alvo[i] < NP)
                ok = m_alive[q_ator[i]] && m_alive[q_alvo[i]];
            if (ok) begin
                if (q_cls[i] == 1 && m_lobos[q_ator[i]])
                    votos[q_alvo[i]] = (votos[q_alvo[i]] >= VMAX) ? VMAX : votos[q_alvo[i]] + 1;
                else if (q_cls[i] == 2 && q_alvo[i] != m_prev)
                    prot = q_alvo[i];
`ifdef RODADA_NOITE_VIDENTE_EN
                else if (q_cls[i] == 3 && !seer_used) begin
                    seer_used = 1'b1;
                    rv = 1'b1;
                    rl = m_lobos[q_alvo[i]];
                end
`endif
            end
            q_rv.push_back(rv);
            q_rl.push_back(rl);
        end
        for (int i = 0; i < NP; i++) begin
            if (votos[i] > bmax) begin
                bmax = votos[i];
                best = i;
            end
        end
        if (bmax > 0 && best != prot) begin
            m_alive[best] = 1'b0;
            m_nvivos--;
            m_vitima = best;
            m_vvalid = 1'b1;
        end else begin
            m_vvalid = 1'b0;
        end
        m_prev = prot;
        for (int i = 0; i < NP; i++) if (m_alive[i] && m_lobos[i]) lv++;
        if (lv == 0) begin
            m_fim = 1'b1;
            m_vl  = 1'b0;
        end else if (lv >= m_nvivos - lv) begin
            m_fim = 1'b1;
            m_vl  = 1'b1;
        end
    endtask

    // Compare process: every idle cycle the outputs must match the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("idle_ocupado", bus.ocupado, 0);
            check("idle_db_estado", bus.db_estado, 0);
            check("idle_noite_pronta", bus.noite_pronta, 0);
            check("vivos_mask", bus.vivos_mask, m_mask());
            check("num_vivos", bus.num_vivos, m_nvivos);
            check("vitima_valid", bus.vitima_valid, m_vvalid);
            check("vitima", bus.vitima, m_vitima);
            check("fim_jogo", bus.fim_jogo, m_fim);
            check("vitoria_lobos", bus.vitoria_lobos, m_vl);
`ifdef RODADA_NOITE_VIDENTE_EN
            check("idle_revela_valid", bus.revela_valid, 0);
`endif
        end
    end

    task automatic drive_idle();
        bus.novo_jogo     = 1'b0;
        bus.inicia_noite  = 1'b0;
        bus.acao_valid    = 1'b0;
        bus.acao_ator     = '0;
        bus.acao_classe   = ALDEAO;
        bus.acao_alvo     = '0;
        bus.encerra_noite = 1'b0;
    endtask

    task automatic push(input int a, input int c, input int t);
        q_ator.push_back(a);
        q_cls.push_back(c);
        q_alvo.push_back(t);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_global_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_global_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic do_novo();
        chk_en = 1'b0;
        @(posedge clock); #1;
        bus.novo_jogo = 1'b1;
        @(posedge clock); #1;
        bus.novo_jogo = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    // Runs the queued actions as one night; encerra_noite either shares the
    // cycle of the last action or follows it.
    task automatic run_night(input bit enc_last);
        int k;
        int n;
        bit e;
        n = q_ator.size();
        e = (n == 0) ? 1'b0 : enc_last;
        chk_en = 1'b0;
        model_night();
        @(posedge clock); #1;
        bus.inicia_noite = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            bus.inicia_noite  = 1'b0;
            bus.acao_valid    = 1'b1;
            bus.acao_ator     = PW'(q_ator[i]);
            bus.acao_classe   = classe_t'(2'(q_cls[i]));
            bus.acao_alvo     = PW'(q_alvo[i]);
            bus.encerra_noite = e && (i == n - 1);
            @(negedge clock);
`ifdef RODADA_NOITE_VIDENTE_EN
            check("revela_valid", bus.revela_valid, (i > 0) ? q_rv[i-1] : 1'b0);
            if (i > 0 && q_rv[i-1]) check("revela_lobo", bus.revela_lobo, q_rl[i-1]);
`endif
        end
        @(posedge clock); #1;
        bus.inicia_noite  = 1'b0;
        bus.acao_valid    = 1'b0;
        bus.encerra_noite = !e;
        @(negedge clock);
`ifdef RODADA_NOITE_VIDENTE_EN
        check("revela_valid", bus.revela_valid, (n > 0) ? q_rv[n-1] : 1'b0);
        if (n > 0 && q_rv[n-1]) check("revela_lobo", bus.revela_lobo, q_rl[n-1]);
`endif
        k = e ? 1 : 0;
        while (bus.noite_pronta !== 1'b1 && k < 40) begin
            @(posedge clock); #1;
            bus.encerra_noite = 1'b0;
            @(negedge clock);
            k++;
        end
        check("latency", k, NP + 3);
        @(posedge clock); #1;
        drive_idle();
        q_ator.delete();
        q_cls.delete();
        q_alvo.delete();
        chk_en = 1'b1;
    endtask

    // inicia_noite after game over must leave the engine idle (compare
    // process watches ocupado every cycle).
    task automatic try_inicia_ignored();
        @(posedge clock); #1;
        bus.inicia_noite = 1'b1;
        @(posedge clock); #1;
        bus.inicia_noite = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic reset_midnight();
        chk_en = 1'b0;
        @(posedge clock); #1;
        bus.inicia_noite = 1'b1;
        @(posedge clock); #1;
        bus.inicia_noite = 1'b0;
        bus.acao_valid   = 1'b1;
        bus.acao_classe  = PROTETOR;
        bus.acao_ator    = PW'($urandom_range(0, NP - 1));
        bus.acao_alvo    = PW'($urandom_range(0, NP - 1));
        @(posedge clock); #1;
        bus.acao_valid = 1'b0;
        check("midnight_ocupado", bus.ocupado, 1);
        rst_global_n = 1'b0;
        @(posedge clock); #1;
        rst_global_n = 1'b1;
        drive_idle();
        model_reset();
        chk_en = 1'b1;
    endtask

    function automatic int pick_wolf();
        int a;
        a = $urandom_range(0, NP - 1);
        while (!m_lobos[a]) a = (a + 1) % NP;
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive_idle();
        m_lobos = 5'b00010;
        bus.lobos_mask = m_lobos;
        do_reset();
        check("rst_vivos", bus.vivos_mask, 5'b11111);
        check("rst_num_vivos", bus.num_vivos, 5);
        check("rst_fim", bus.fim_jogo, 0);
        check("rst_estado", bus.db_estado, 0);

        // Wolf 1 attacks 3, protector saves 4; noise actions are ignored.
        push(1, 1, 3); push(2, 2, 4); push(1, 1, 6); push(3, 0, 0);
        run_night(1'b0);
        check("t1_vitima", bus.vitima, 3);
        check("t1_vvalid", bus.vitima_valid, 1);
        check("t1_vivos", bus.vivos_mask, 5'b10111);
        check("t1_num", bus.num_vivos, 4);
        check("t1_fim", bus.fim_jogo, 0);

        // Same attack, but 3 is protected.
        do_novo();
        push(1, 1, 3); push(2, 2, 3);
        run_night(1'b1);
        check("t2_vvalid", bus.vitima_valid, 0);
        check("t2_vivos", bus.vivos_mask, 5'b11111);

        // Next night: protecting 3 again is rejected.
        push(2, 2, 3); push(1, 1, 3);
        run_night(1'b0);
        check("t3_vitima", bus.vitima, 3);
        check("t3_vivos", bus.vivos_mask, 5'b10111);

        // Saturation: 9 votes on 2 and 7 on 0 both clamp to 7 -> tie -> 0.
        do_novo();
        for (int i = 0; i < 9; i++) push(1, 1, 2);
        for (int i = 0; i < 7; i++) push(1, 1, 0);
        run_night(1'b0);
        check("sat_vitima", bus.vitima, 0);

        // Two wolves tie on 2 and 4 -> 2 dies, wolves reach parity.
        m_lobos = 5'b00011;
        bus.lobos_mask = m_lobos;
        do_novo();
        push(4, 3, 1); push(3, 3, 0); push(0, 1, 2); push(1, 1, 4);
        run_night(1'b1);
        check("t4_vitima", bus.vitima, 2);
        check("t4_vivos", bus.vivos_mask, 5'b11011);
        check("t4_fim", bus.fim_jogo, 1);
        check("t4_vitoria", bus.vitoria_lobos, 1);
        try_inicia_ignored();

        // Randomized games.
        for (int g = 0; g < 25; g++) begin
            m_lobos = '0;
            m_lobos[$urandom_range(0, NP - 1)] = 1'b1;
            if ($urandom_range(0, 1) == 1) m_lobos[$urandom_range(0, NP - 1)] = 1'b1;
            bus.lobos_mask = m_lobos;
            do_novo();
            for (int nt = 0; nt < 10 && !m_fim; nt++) begin
                int n;
                if ($urandom_range(0, 19) == 0) reset_midnight();
                n = $urandom_range(0, 8);
                for (int a = 0; a < n; a++) begin
                    int c, at, t;
                    c = ($urandom_range(0, 9) < 6) ? 1 : int'($urandom_range(0, 3));
                    at = (c == 1 && $urandom_range(0, 4) != 0) ? pick_wolf() : int'($urandom_range(0, 7));
                    t = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NP - 1)) : int'($urandom_range(0, 7));
                    push(at, c, t);
                end
                run_night(1'($urandom_range(0, 1)));
            end
            if (m_fim) try_inicia_ignored();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
